lct_l1a_match: RTL and testbench
================================

# lct_l1a_match

Per-CFEB pre-LCT / L1A matching stage that sits directly upstream of the trigger encoder. It edge-detects the five raw CFEB pre-LCT inputs, keeps a programmable-depth history of them, and tags each incoming L1A with the set of CFEBs whose pre-LCT fell inside a 3-cycle window at the programmed LCT-to-L1A delay. It also stretches RESYNC into the encoder's reset code. Outputs feed the encoder's `PRE_LCT_OUT`, `L1A_MATCH`, `L1ACFEB` and `RESYNC_RST` inputs.

## Interface
- `DLY_W`, 8: width of the delay setting; the history depth is 2^DLY_W cycles.
- `RST_CYC`, 4: length of the `RESYNC_RST` stretch, in cycles.
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RSTN` in 1: reset, synchronous, active-low.
- `LCT` in [5:1]: raw per-CFEB pre-LCT levels, synchronous to `CLK`.
- `L1A` in 1: level-1 accept, one pulse per accept.
- `RESYNC` in 1: TTC resync pulse.
- `LCT_L1A_DLY` in [DLY_W-1:0]: LCT-to-L1A delay in cycles; the legal range is 2..2^DLY_W-2.
- `PRE_LCT_OUT` out [5:1]: one-cycle pulse on each LCT rising edge.
- `L1A_MATCH` out [5:1]: per-CFEB match flag, valid while `L1ACFEB` is high.
- `L1ACFEB` out 1: one-cycle accepted-L1A strobe.
- `RESYNC_RST` out 1: stretched resync.
- `L1A_CNT` out [23:0]: count of accepted L1As.
- `MATCH_CNT` out [59:0]: per-CFEB 12-bit match counters; CFEB i occupies bits [12i-1:12i-12].

## Operation
- **Edge detect.** `PRE_LCT_OUT[i]` is set to `LCT[i] & ~lct_q[i]`, registered. The delay flop `lct_q` resets to all ones, so an LCT that is already high at reset release produces no pulse. A held level produces exactly one pulse.
- **History.** A circular buffer of 2^DLY_W × 5 bits is written with `PRE_LCT_OUT` every cycle. The write pointer wraps from 2^DLY_W-1 to 0.
- **Delay clamp.** `LCT_L1A_DLY` values below 2 are treated as 2. Values above 2^DLY_W-2 are treated as 2^DLY_W-2. A new delay value takes effect on the next cycle.
- **Match rule.** Let an L1A be sampled at cycle t and D be the clamped delay. `L1A_MATCH[i]` = 1 if and only if `PRE_LCT_OUT[i]` was 1 in any of cycles t-D-1, t-D or t-D+1.
- **Accept rule.** An L1A is accepted when `RESYNC` = 0, `RESYNC_RST` = 0 and the hold-off counter is 0.
  - Accepted: `L1ACFEB` pulses and `L1A_CNT` increments, wrapping from FFFFFF to 0.
  - Not accepted: the L1A is dropped and not counted.
- **Resync.**
  - A `RESYNC` pulse drives `RESYNC_RST` high for exactly `RST_CYC` cycles.
  - A further `RESYNC` during the stretch restarts it to a full `RST_CYC`.
  - `RESYNC` clears `L1A_CNT` and `MATCH_CNT`.
  - It loads a hold-off counter with 2^DLY_W. L1As are ignored while the counter is nonzero, which blocks stale history from matching. The counter decrements once per cycle.
- **Simultaneous events.** `RESYNC` and `L1A` in the same cycle: resync wins and the L1A is dropped. Back-to-back L1As each produce their own strobe and match vector.
- **Reset values.** All outputs are 0: `PRE_LCT_OUT`, `L1A_MATCH`, `L1ACFEB`, `RESYNC_RST`, `L1A_CNT`, `MATCH_CNT`.
  - The hold-off counter resets to 2^DLY_W.
  - Buffer contents are don't-care, because hold-off covers them.
  - Reset asserted mid-stretch or mid-hold-off aborts immediately to the reset state.

## Timing
- `PRE_LCT_OUT`: latency 1 cycle from the `LCT` rising edge.
- `L1ACFEB` and `L1A_MATCH`: latency 1 cycle from the sampled `L1A` (cycle t+1). Both are high for 1 cycle. `L1A_MATCH` is 0 whenever `L1ACFEB` is 0.
- `L1A_CNT`: updates in the same cycle that `L1ACFEB` is asserted.
- `RESYNC_RST`: high in cycles t+1 .. t+`RST_CYC` for a `RESYNC` sampled at cycle t. The hold-off counter is loaded at t+1.
- Buffer read taps are registered. The implementation meets the t+1 latency by reading ahead.

## Configuration
- `LCT_MATCH_CNT_EN` defined:
  - Each CFEB has a 12-bit counter that increments on every cycle where `L1ACFEB` & `L1A_MATCH[i]`.
  - Counters saturate at FFF.
  - Counters clear on reset and on `RESYNC`.
- `LCT_MATCH_CNT_EN` undefined: the counters are not built and `MATCH_CNT` is tied to 0.

## Test plan
- **Match at delay.** `LCT_L1A_DLY`=20; rise `LCT[3]` so `PRE_LCT_OUT[3]` pulses at cycle 100; `L1A` at 119, 120 and 121 (separate runs) → each gives `L1ACFEB`=1 with `L1A_MATCH`=5'b00100 one cycle later. `L1A` at 118 or 122 gives `L1A_MATCH`=0.
- **Edge-only behaviour.** Hold `LCT[1]` high for 50 cycles → exactly one `PRE_LCT_OUT[1]` pulse. `LCT` high through reset release → no pulse.
- **Resync priority.** `RESYNC` and `L1A` in the same cycle → `RESYNC_RST` high for 4 cycles, no `L1ACFEB`, `L1A_CNT` cleared. An L1A at 100 cycles after resync with `DLY_W`=8 is dropped. An L1A at 260 cycles after resync is accepted.
- **Counter wrap.** Preload `L1A_CNT` toward FFFFFE → two accepted L1As give FFFFFF then 000000. Back-to-back L1As yield consecutive strobes.
- **Delay clamp.** `LCT_L1A_DLY`=0 behaves identically to `LCT_L1A_DLY`=2. `LCT_L1A_DLY`=255 behaves as 254 and matches across pointer wrap.
- **Macro.** With `LCT_MATCH_CNT_EN`, 4097 matched L1As on CFEB5 → `MATCH_CNT[59:48]`=FFF. Without the macro, `MATCH_CNT`=0.

Source files
------------

// File: rtl/lct_l1a_match.sv
// rtl/lct_l1a_match.sv - per-CFEB pre-LCT edge detect, history buffer and L1A match tagging; optional match counters under LCT_MATCH_CNT_EN
module lct_l1a_match #(
   parameter int DLY_W   = 8,
   parameter int RST_CYC = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [5:1]       LCT,
   input  logic             L1A,
   input  logic             RESYNC,
   input  logic [DLY_W-1:0] LCT_L1A_DLY,
   output logic [5:1]       PRE_LCT_OUT,
   output logic [5:1]       L1A_MATCH,
   output logic             L1ACFEB,
   output logic             RESYNC_RST,
   output logic [23:0]      L1A_CNT,
   output logic [59:0]      MATCH_CNT
);

   localparam int               DEPTH   = 1 << DLY_W;
   localparam int               HO_W    = DLY_W + 1;
   localparam int               RST_W   = $clog2(RST_CYC + 1);
   localparam logic [DLY_W-1:0] DLY_MIN = DLY_W'(2);
   localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(DEPTH - 2);
   localparam logic [HO_W-1:0]  HO_INIT = HO_W'(DEPTH);

   logic [5:1]       lct_q;
   logic [DLY_W-1:0] wp;
   logic [DLY_W-1:0] dly_clamp;
   logic [DLY_W-1:0] dly_q;
   logic [DLY_W-1:0] addr_a;
   logic [DLY_W-1:0] addr_b;
   logic [DLY_W-1:0] addr_c;
   logic [5:1]       mem [DEPTH];
   logic [5:1]       tap_a;
   logic [5:1]       tap_b;
   logic [5:1]       tap_c;
   logic [RST_W-1:0] rst_cnt;
   logic [HO_W-1:0]  holdoff;
   logic [23:0]      l1a_cnt;
   logic             accept;

   // Clamp the programmed delay into the range the buffer depth can serve
   always_comb begin
      dly_clamp = LCT_L1A_DLY;
      if (LCT_L1A_DLY < DLY_MIN) begin
         dly_clamp = DLY_MIN;
      end else if (LCT_L1A_DLY > DLY_MAX) begin
         dly_clamp = DLY_MAX;
      end
   end

   // Read one cycle ahead of the L1A: while in cycle t-1 the write pointer
   // holds the slot of cycle t-1, so cycle t-k sits at wp-(k-1).
   assign addr_a = wp - dly_q;                 // cycle t-D-1
   assign addr_b = wp - dly_q + DLY_W'(1);     // cycle t-D
   assign addr_c = wp - dly_q + DLY_W'(2);     // cycle t-D+1

   // Edge detect, write pointer and delay register
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         lct_q       <= '1;
         PRE_LCT_OUT <= '0;
         wp          <= '0;
         dly_q       <= DLY_MIN;
      end else begin
         lct_q       <= LCT;
         PRE_LCT_OUT <= LCT & ~lct_q;
         wp          <= wp + DLY_W'(1);
         dly_q       <= dly_clamp;
      end
   end

   // History buffer and registered read taps; at the minimum delay the newest
   // tap is the entry being written this cycle, so it is bypassed from the edge register
   always_ff @(posedge CLK) begin
      mem[wp] <= PRE_LCT_OUT;
      tap_a   <= mem[addr_a];
      tap_b   <= mem[addr_b];
      tap_c   <= (dly_q == DLY_MIN) ? PRE_LCT_OUT : mem[addr_c];
   end

   assign RESYNC_RST = (rst_cnt != '0);
   assign accept     = L1A && !RESYNC && !RESYNC_RST && (holdoff == '0);
   assign L1A_CNT    = l1a_cnt;

   // Resync stretch, hold-off, L1A strobe/match and accepted-L1A counter
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rst_cnt   <= '0;
         holdoff   <= HO_INIT;
         L1ACFEB   <= 1'b0;
         L1A_MATCH <= '0;
         l1a_cnt   <= '0;
      end else begin
         L1ACFEB   <= accept;
         L1A_MATCH <= accept ? (tap_a | tap_b | tap_c) : 5'b0;
         if (RESYNC) begin
            rst_cnt <= RST_W'(RST_CYC);
            holdoff <= HO_INIT;
            l1a_cnt <= '0;
         end else begin
            if (rst_cnt != '0) begin
               rst_cnt <= rst_cnt - RST_W'(1);
            end
            if (holdoff != '0) begin
               holdoff <= holdoff - HO_W'(1);
            end
            if (accept) begin
               l1a_cnt <= l1a_cnt + 24'd1;
            end
         end
      end
   end

`ifdef LCT_MATCH_CNT_EN
   logic [11:0] match_cnt [1:5];

   // Saturating per-CFEB match counters, cleared by reset and resync
   always_ff @(posedge CLK) begin
      if (!RSTN || RESYNC) begin
         for (int i = 1; i <= 5; i++) begin
            match_cnt[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= 5; i++) begin
            if (L1ACFEB && L1A_MATCH[i] && (match_cnt[i] != 12'hFFF)) begin
               match_cnt[i] <= match_cnt[i] + 12'd1;
            end
         end
      end
   end

   for (genvar g = 1; g <= 5; g++) begin : g_match_cnt
      assign MATCH_CNT[12*g-1 -: 12] = match_cnt[g];
   end
`else
   assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_lct_l1a_match.sv
// tb/tb_lct_l1a_match.sv - directed self-checking bench for lct_l1a_match
module tb_lct_l1a_match;

   localparam int DLY_W = 8;

   logic             CLK;
   logic             RSTN;
   logic [5:1]       LCT;
   logic             L1A;
   logic             RESYNC;
   logic [DLY_W-1:0] LCT_L1A_DLY;
   logic [5:1]       PRE_LCT_OUT;
   logic [5:1]       L1A_MATCH;
   logic             L1ACFEB;
   logic             RESYNC_RST;
   logic [23:0]      L1A_CNT;
   logic [59:0]      MATCH_CNT;

   int          n_cmp;
   int          n_fail;
   logic [23:0] exp_cnt;

   lct_l1a_match #(.DLY_W(DLY_W), .RST_CYC(4)) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .LCT         (LCT),
      .L1A         (L1A),
      .RESYNC      (RESYNC),
      .LCT_L1A_DLY (LCT_L1A_DLY),
      .PRE_LCT_OUT (PRE_LCT_OUT),
      .L1A_MATCH   (L1A_MATCH),
      .L1ACFEB     (L1ACFEB),
      .RESYNC_RST  (RESYNC_RST),
      .L1A_CNT     (L1A_CNT),
      .MATCH_CNT   (MATCH_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Pulse mask at relative cycle 100, L1A at 100+off, expect exp_m one cycle later
   task automatic run_match(input logic [DLY_W-1:0] dly, input logic [5:1] mask,
                            input int off, input logic [5:1] exp_m, input string name);
      LCT_L1A_DLY = dly;
      repeat (5) @(negedge CLK);
      LCT = mask;
      @(negedge CLK);
      n_cmp++;
      if (PRE_LCT_OUT !== mask) begin
         n_fail++;
         $display("FAIL %s pre_lct: got %b want %b", name, PRE_LCT_OUT, mask);
      end
      LCT = '0;
      repeat (off) @(negedge CLK);
      L1A = 1'b1;
      @(negedge CLK);
      L1A = 1'b0;
      exp_cnt = exp_cnt + 24'd1;
      n_cmp++;
      if (L1ACFEB !== 1'b1) begin
         n_fail++;
         $display("FAIL %s strobe: got %b want 1", name, L1ACFEB);
      end
      n_cmp++;
      if (L1A_MATCH !== exp_m) begin
         n_fail++;
         $display("FAIL %s match: got %b want %b", name, L1A_MATCH, exp_m);
      end
      n_cmp++;
      if (L1A_CNT !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s l1a_cnt: got %h want %h", name, L1A_CNT, exp_cnt);
      end
      @(negedge CLK);
      n_cmp++;
      if ((L1ACFEB !== 1'b0) || (L1A_MATCH !== 5'b0)) begin
         n_fail++;
         $display("FAIL %s one_cycle: got strobe %b match %b want 0 00000", name, L1ACFEB, L1A_MATCH);
      end
   endtask

   task automatic test_reset;
      int pulses;
      RSTN = 1'b0; LCT = 5'h1F; L1A = 1'b0; RESYNC = 1'b0; LCT_L1A_DLY = 8'd20;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ((PRE_LCT_OUT !== 5'b0) || (L1A_MATCH !== 5'b0) || (L1ACFEB !== 1'b0) ||
          (RESYNC_RST !== 1'b0) || (L1A_CNT !== 24'b0) || (MATCH_CNT !== 60'b0)) begin
         n_fail++;
         $display("FAIL reset_values: got pre %b match %b strobe %b rst %b cnt %h mcnt %h want all 0",
                  PRE_LCT_OUT, L1A_MATCH, L1ACFEB, RESYNC_RST, L1A_CNT, MATCH_CNT);
      end
      RSTN = 1'b1; RESYNC = 1'b1;
      @(negedge CLK);
      RESYNC = 1'b0;
      n_cmp++;
      if (RESYNC_RST !== 1'b1) begin
         n_fail++;
         $display("FAIL stretch_start: got %b want 1", RESYNC_RST);
      end
      RSTN = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (RESYNC_RST !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort_stretch: got %b want 0", RESYNC_RST);
      end
      RSTN = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge CLK);
         if (PRE_LCT_OUT != 5'b0) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL lct_high_at_release: got %0d pulses want 0", pulses);
      end
      L1A = 1'b1;
      @(negedge CLK);
      L1A = 1'b0;
      n_cmp++;
      if (L1ACFEB !== 1'b0) begin
         n_fail++;
         $display("FAIL holdoff_after_reset: got strobe %b want 0", L1ACFEB);
      end
      LCT = '0;
      repeat (260) @(negedge CLK);
   endtask

   task automatic test_edge;
      int pulses;
      pulses = 0;
      LCT = 5'b00001;
      repeat (50) begin
         @(negedge CLK);
         if (PRE_LCT_OUT[1]) pulses++;
      end
      LCT = '0;
      n_cmp++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL held_level_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_match_at_delay;
      run_match(8'd20, 5'b00100, 19, 5'b00100, "d20_t119");
      run_match(8'd20, 5'b00100, 20, 5'b00100, "d20_t120");
      run_match(8'd20, 5'b00100, 21, 5'b00100, "d20_t121");
      run_match(8'd20, 5'b00100, 18, 5'b00000, "d20_t118");
      run_match(8'd20, 5'b00100, 22, 5'b00000, "d20_t122");
      run_match(8'd20, 5'b10010, 20, 5'b10010, "d20_multi");
   endtask

   task automatic test_delay_clamp;
      logic [5:1] exp_tab [5];
      exp_tab[0] = 5'b00000; exp_tab[1] = 5'b01000; exp_tab[2] = 5'b01000;
      exp_tab[3] = 5'b01000; exp_tab[4] = 5'b00000;
      for (int k = 0; k < 5; k++) begin
         run_match(8'd0, 5'b01000, k, exp_tab[k], "d0_as_2");
         run_match(8'd2, 5'b01000, k, exp_tab[k], "d2");
      end
      for (int k = 0; k < 5; k++) begin
         run_match(8'd255, 5'b01000, 252 + k, exp_tab[k], "d255_as_254");
      end
   endtask

   task automatic test_back_to_back;
      @(negedge CLK);
      force dut.l1a_cnt = 24'hFFFFFE;
      #1;
      release dut.l1a_cnt;
      L1A = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ((L1ACFEB !== 1'b1) || (L1A_CNT !== 24'hFFFFFF)) begin
         n_fail++;
         $display("FAIL wrap_first: got strobe %b cnt %h want 1 ffffff", L1ACFEB, L1A_CNT);
      end
      @(negedge CLK);
      L1A = 1'b0;
      n_cmp++;
      if ((L1ACFEB !== 1'b1) || (L1A_CNT !== 24'h000000)) begin
         n_fail++;
         $display("FAIL wrap_second: got strobe %b cnt %h want 1 000000", L1ACFEB, L1A_CNT);
      end
      @(negedge CLK);
      n_cmp++;
      if (L1ACFEB !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: got strobe %b want 0", L1ACFEB);
      end
      exp_cnt = 24'h000000;
   endtask

   task automatic test_resync;
      int hi;
      // restart during the stretch: RESYNC at t and t+2 -> high t+1..t+6
      RESYNC = 1'b1;
      @(negedge CLK);
      RESYNC = 1'b0;
      hi = RESYNC_RST ? 1 : 0;
      @(negedge CLK);
      if (RESYNC_RST) hi++;
      RESYNC = 1'b1;
      @(negedge CLK);
      RESYNC = 1'b0;
      if (RESYNC_RST) hi++;
      repeat (7) begin
         @(negedge CLK);
         if (RESYNC_RST) hi++;
      end
      n_cmp++;
      if (hi !== 6) begin
         n_fail++;
         $display("FAIL stretch_restart: got %0d cycles want 6", hi);
      end
      // same-cycle RESYNC and L1A
      RESYNC = 1'b1; L1A = 1'b1;
      @(negedge CLK);
      RESYNC = 1'b0; L1A = 1'b0;
      n_cmp++;
      if (L1ACFEB !== 1'b0) begin
         n_fail++;
         $display("FAIL resync_wins: got strobe %b want 0", L1ACFEB);
      end
      n_cmp++;
      if (L1A_CNT !== 24'h0) begin
         n_fail++;
         $display("FAIL resync_clears_cnt: got %h want 000000", L1A_CNT);
      end
      hi = RESYNC_RST ? 1 : 0;
      repeat (7) begin
         @(negedge CLK);
         if (RESYNC_RST) hi++;
      end
      n_cmp++;
      if (hi !== 4) begin
         n_fail++;
         $display("FAIL stretch_len: got %0d cycles want 4", hi);
      end
      exp_cnt = 24'h0;
      // now in cycle t+8; drive L1A in cycle t+100
      repeat (92) @(negedge CLK);
      L1A = 1'b1;
      @(negedge CLK);
      L1A = 1'b0;
      n_cmp++;
      if (L1ACFEB !== 1'b0) begin
         n_fail++;
         $display("FAIL holdoff_drop_t100: got strobe %b want 0", L1ACFEB);
      end
      // now in cycle t+101; drive L1A in cycle t+260
      repeat (159) @(negedge CLK);
      L1A = 1'b1;
      @(negedge CLK);
      L1A = 1'b0;
      exp_cnt = 24'd1;
      n_cmp++;
      if ((L1ACFEB !== 1'b1) || (L1A_CNT !== exp_cnt)) begin
         n_fail++;
         $display("FAIL accept_t260: got strobe %b cnt %h want 1 %h", L1ACFEB, L1A_CNT, exp_cnt);
      end
   endtask

   task automatic test_match_cnt;
`ifdef LCT_MATCH_CNT_EN
      LCT_L1A_DLY = 8'd20;
      for (int i = 0; i < 30; i++) begin
         LCT = LCT ^ 5'b10000;
         @(negedge CLK);
      end
      for (int i = 0; i < 4097; i++) begin
         LCT = LCT ^ 5'b10000;
         L1A = 1'b1;
         @(negedge CLK);
      end
      L1A = 1'b0;
      LCT = '0;
      exp_cnt = exp_cnt + 24'd4097;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if (MATCH_CNT[59:48] !== 12'hFFF) begin
         n_fail++;
         $display("FAIL match_cnt_sat: got %h want fff", MATCH_CNT[59:48]);
      end
      n_cmp++;
      if (MATCH_CNT[47:0] !== 48'h0) begin
         n_fail++;
         $display("FAIL match_cnt_others: got %h want 0", MATCH_CNT[47:0]);
      end
      n_cmp++;
      if (L1A_CNT !== exp_cnt) begin
         n_fail++;
         $display("FAIL match_cnt_l1a_cnt: got %h want %h", L1A_CNT, exp_cnt);
      end
`else
      run_match(8'd20, 5'b10000, 20, 5'b10000, "cfeb5_no_cnt");
      @(negedge CLK);
      n_cmp++;
      if (MATCH_CNT !== 60'h0) begin
         n_fail++;
         $display("FAIL match_cnt_tied: got %h want 0", MATCH_CNT);
      end
`endif
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      exp_cnt = 24'h0;
      test_reset();
      test_edge();
      test_match_at_delay();
      test_delay_clamp();
      test_back_to_back();
      test_resync();
      test_match_cnt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
